sa_deskew: RTL and testbench

Downstream drain stage for the systolic-array core. It accepts the column-skewed result stream leaving the bottom edge of the PE array, where column j emits its elements j cycles after column 0. It buffers each column independently and re-emits complete, time-aligned rows of C over a valid/ready handshake. The core cannot stall, so this block absorbs skew and downstream back-pressure and flags any loss.

---
 rtl/sa_deskew.sv | 113 +++++++++++
 tb/tb_sa_deskew.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_deskew.sv
// sa_deskew: drain stage for the systolic-array core.
// Buffers the column-skewed result stream from the bottom edge of the PE
// array in one FIFO per column and re-emits complete, time-aligned rows of C
// over a valid/ready handshake. Elements that arrive at a full column are
// dropped and flagged with a sticky overflow bit.
//
// Ports:
//   clk         single clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   i_c_vld     per-column valid from the core bottom edge
//   i_c_rows    per-column C element from the core bottom edge
//   o_row_vld   aligned row available (every column FIFO non-empty)
//   i_row_rdy   downstream accepts the presented row
//   o_row       aligned row of C, element j = head of column j
//   i_clear     synchronous flush of FIFOs, row counter and overflow flag
//   o_overflow  sticky: at least one element dropped
//   o_busy      any column FIFO non-empty
//   o_row_cnt   rows delivered since reset/clear, wraps at 2^16
module sa_deskew #(
   parameter int WIDTH = 16,
   parameter int SIZE  = 4,
   parameter int DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [SIZE-1:0]             i_c_vld,
   input  logic [SIZE-1:0][WIDTH-1:0]  i_c_rows,
   output logic                        o_row_vld,
   input  logic                        i_row_rdy,
   output logic [SIZE-1:0][WIDTH-1:0]  o_row,
   input  logic                        i_clear,
   output logic                        o_overflow,
   output logic                        o_busy,
   output logic [15:0]                 o_row_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [SIZE-1:0] not_empty;
   logic [SIZE-1:0] drop;
   logic            pop;

   assign o_row_vld = &not_empty;
   assign o_busy    = |not_empty;
   // All columns advance together, so one pop strobe serves every FIFO.
   assign pop       = o_row_vld & i_row_rdy;

   for (genvar j = 0; j < SIZE; j++) begin : g_col
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    wr_ptr;
      logic [AW-1:0]    rd_ptr;
      logic [AW:0]      count;
      logic             full;
      logic             push;

      assign full         = (count == FULL);
      // A full column still accepts a write when the same cycle frees a slot.
      assign push         = i_c_vld[j] & (~full | pop);
      assign drop[j]      = i_c_vld[j] & full & ~pop;
      assign not_empty[j] = (count != '0);
      assign o_row[j]     = mem[rd_ptr];

      // Storage is intentionally not reset; only pointers and counts are.
      always_ff @(posedge clk) begin
         if (push && !i_clear) begin
            mem[wr_ptr] <= i_c_rows[j];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_overflow <= 1'b0;
         o_row_cnt  <= '0;
      end else if (i_clear) begin
         o_overflow <= 1'b0;
         o_row_cnt  <= '0;
      end else begin
         if (|drop) begin
            o_overflow <= 1'b1;
         end
         if (pop) begin
            o_row_cnt <= o_row_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sa_deskew.sv
// tb_sa_deskew: scoreboard bench for sa_deskew (WIDTH=16, SIZE=4, DEPTH=8).
// Stimulus pushes expected rows into a queue; a monitor on the falling edge
// pops and compares whenever a row is handed over (o_row_vld && i_row_rdy).
module tb_sa_deskew;

   localparam int WIDTH = 16;
   localparam int SIZE  = 4;
   localparam int DEPTH = 8;

   typedef logic [SIZE-1:0][WIDTH-1:0] row_t;

   logic        clk;
   logic        rst_n;
   logic [SIZE-1:0] i_c_vld;
   row_t        i_c_rows;
   logic        o_row_vld;
   logic        i_row_rdy;
   row_t        o_row;
   logic        i_clear;
   logic        o_overflow;
   logic        o_busy;
   logic [15:0] o_row_cnt;

   int   checks;
   int   errors;
   row_t exp_q[$];

   sa_deskew #(.WIDTH(WIDTH), .SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_c_vld    (i_c_vld),
      .i_c_rows   (i_c_rows),
      .o_row_vld  (o_row_vld),
      .i_row_rdy  (i_row_rdy),
      .o_row      (o_row),
      .i_clear    (i_clear),
      .o_overflow (o_overflow),
      .o_busy     (o_busy),
      .o_row_cnt  (o_row_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic row_t mkrow(input int base, input int k);
      row_t r;
      for (int j = 0; j < SIZE; j++) r[j] = WIDTH'(base + 16 * k + j);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive n rows with core skew: column j carries row k at cycle k+j.
   task automatic push_rows(input int n, input int base, input bit expect_out);
      if (expect_out) begin
         for (int k = 0; k < n; k++) exp_q.push_back(mkrow(base, k));
      end
      for (int c = 0; c < n + SIZE - 1; c++) begin
         for (int j = 0; j < SIZE; j++) begin
            int k;
            k = c - j;
            i_c_vld[j]  = (k >= 0 && k < n);
            i_c_rows[j] = WIDTH'(base + 16 * k + j);
         end
         step();
      end
      i_c_vld = '0;
   endtask

   always @(negedge clk) begin
      if (rst_n && o_row_vld && i_row_rdy) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row: got %h expected none at %0t", o_row, $time);
         end else begin
            check("row", o_row, exp_q.pop_front());
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b1;
      i_c_vld   = '0;
      i_c_rows  = '0;
      i_row_rdy = 1'b0;
      i_clear   = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) step();
      check("rst_vld", o_row_vld, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_ovf", o_overflow, 1'b0);
      check("rst_cnt", o_row_cnt, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Skewed single row: valid only after the last column pushes.
      i_row_rdy = 1'b1;
      exp_q.push_back(mkrow('h100, 0));
      for (int c = 0; c < SIZE; c++) begin
         i_c_vld  = '0;
         i_c_vld[c] = 1'b1;
         i_c_rows[c] = WIDTH'('h100 + c);
         step();
         if (c < SIZE - 1) check("t1_vld_early", o_row_vld, 1'b0);
         else              check("t1_vld_on", o_row_vld, 1'b1);
      end
      i_c_vld = '0;
      step();
      check("t1_vld_off", o_row_vld, 1'b0);
      check("t1_busy", o_busy, 1'b0);
      check("t1_cnt", o_row_cnt, 16'd1);

      // Streaming 4 rows with ready held: one row per cycle.
      push_rows(4, 'h000, 1'b1);
      check("t2_vld", o_row_vld, 1'b1);
      check("t2_cnt_mid", o_row_cnt, 16'd4);
      step();
      check("t2_cnt", o_row_cnt, 16'd5);
      check("t2_busy", o_busy, 1'b0);
      check("t2_ovf", o_overflow, 1'b0);

      // Back-pressure: 8 rows fit, the 9th is dropped.
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      check("t3_clr_cnt", o_row_cnt, 16'd0);
      i_row_rdy = 1'b0;
      push_rows(8, 'h200, 1'b1);
      check("t3_ovf0", o_overflow, 1'b0);
      push_rows(1, 'h300, 1'b0);
      check("t3_ovf1", o_overflow, 1'b1);
      check("t3_head", o_row, mkrow('h200, 0));
      check("t3_vld_hold", o_row_vld, 1'b1);
      i_row_rdy = 1'b1;
      repeat (8) step();
      check("t3_cnt", o_row_cnt, 16'd8);
      check("t3_busy", o_busy, 1'b0);
      check("t3_ovf_sticky", o_overflow, 1'b1);

      // Full column with simultaneous pop: write accepted, no drop.
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      check("t4_clr_ovf", o_overflow, 1'b0);
      i_row_rdy = 1'b0;
      push_rows(8, 'h400, 1'b1);
      exp_q.push_back({16'h04F3, 16'h04F2, 16'h04F1, 16'h04F0});
      i_row_rdy   = 1'b1;
      i_c_vld     = 4'b0001;
      i_c_rows[0] = 16'h04F0;
      step();
      i_c_vld = '0;
      check("t4_ovf", o_overflow, 1'b0);
      repeat (7) step();
      check("t4_vld", o_row_vld, 1'b0);
      check("t4_busy", o_busy, 1'b1);
      check("t4_cnt", o_row_cnt, 16'd8);
      check("t4_col0_head", o_row[0], 16'h04F0);
      i_c_vld  = 4'b1110;
      i_c_rows = {16'h04F3, 16'h04F2, 16'h04F1, 16'h0000};
      step();
      i_c_vld = '0;
      check("t4_vld_last", o_row_vld, 1'b1);
      step();
      check("t4_cnt_last", o_row_cnt, 16'd9);
      check("t4_busy_last", o_busy, 1'b0);

      // Clear with 3 rows buffered and a push in the same cycle.
      i_row_rdy = 1'b0;
      push_rows(3, 'h500, 1'b0);
      check("t5_busy_pre", o_busy, 1'b1);
      i_clear  = 1'b1;
      i_c_vld  = '1;
      i_c_rows = mkrow('h580, 0);
      step();
      i_clear = 1'b0;
      i_c_vld = '0;
      check("t5_busy", o_busy, 1'b0);
      check("t5_vld", o_row_vld, 1'b0);
      check("t5_cnt", o_row_cnt, 16'd0);
      check("t5_ovf", o_overflow, 1'b0);
      step();
      check("t5_busy_after", o_busy, 1'b0);

      // Async reset between edges with data buffered.
      push_rows(2, 'h600, 1'b0);
      check("t6_vld_pre", o_row_vld, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_vld", o_row_vld, 1'b0);
      check("t6_busy", o_busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("t6_vld_rel", o_row_vld, 1'b0);
      i_row_rdy = 1'b1;
      push_rows(1, 'h700, 1'b1);
      step();
      check("t6_cnt", o_row_cnt, 16'd1);
      check("t6_busy_end", o_busy, 1'b0);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
